cvita_pkt_rr_mux: RTL

// - Packet-atomic round-robin arbiter/mux: NUM_PORTS 64-bit CVITA AXI-Stream inputs share one output.
// - A granted input owns the output from its header word to its tlast word; no interleaving of packets.
// - Optional rewrite of the header seqno field with an output-side counter, giving downstream one gap-free stream.
// - Sits between CE/radio packet sources and a shared crossbar or transport port.
//

---
 rtl/cvita_pkg.sv | 54 +++++
 rtl/cvita_rr_arb_sel.sv | 42 ++++
 rtl/cvita_pkt_rr_mux.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cvita_pkg.sv
// ---------------------------------------------------------------------------
// cvita_pkg
// Shared types and helpers for the CVITA packet round-robin mux.
//   - fsm_state_t : arbitration/transfer state of the mux
//   - cvita_hdr_t : field view of a 64-bit CVITA header word
//   - cvita_pkt_t : one AXI-Stream beat (data + last)
//   - hdr_unflatten / hdr_flatten : word <-> header struct conversion
//   - hdr_set_seqno : return a header word with only the seqno field replaced
// ---------------------------------------------------------------------------
package cvita_pkg;

  localparam int PKT_W     = 64;
  localparam int SEQNO_MSB = 59;
  localparam int SEQNO_LSB = 48;
  localparam int SEQNO_W   = SEQNO_MSB - SEQNO_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } fsm_state_t;

  // Packed MSB-first, so the struct overlays the header word bit for bit.
  typedef struct packed {
    logic [1:0]         pkt_type;  // [63:62]
    logic               has_time;  // [61]
    logic               eob;       // [60]
    logic [SEQNO_W-1:0] seqno;     // [59:48]
    logic [15:0]        length;    // [47:32]
    logic [31:0]        sid;       // [31:0]
  } cvita_hdr_t;

  typedef struct packed {
    logic [PKT_W-1:0] tdata;
    logic             tlast;
  } cvita_pkt_t;

  function automatic cvita_hdr_t hdr_unflatten(input logic [PKT_W-1:0] word);
    return cvita_hdr_t'(word);
  endfunction

  function automatic logic [PKT_W-1:0] hdr_flatten(input cvita_hdr_t hdr);
    return PKT_W'(hdr);
  endfunction

  function automatic logic [PKT_W-1:0] hdr_set_seqno(input logic [PKT_W-1:0] word,
                                                     input logic [SEQNO_W-1:0] seqno);
    cvita_hdr_t hdr;
    hdr       = hdr_unflatten(word);
    hdr.seqno = seqno;
    return hdr_flatten(hdr);
  endfunction

endpackage

// File: rtl/cvita_rr_arb_sel.sv
// ---------------------------------------------------------------------------
// cvita_rr_arb_sel
// Combinational rotating-priority encoder. Searches req_i starting at
// last_grant_i+1 and wrapping at NUM_PORTS-1, so the port that was served
// last is considered last.
// Ports:
//   req_i        [NUM_PORTS]  request vector (one bit per input port)
//   last_grant_i [GW]         port that most recently completed a packet
//   grant_o      [GW]         selected port (0 when nothing requests)
//   any_req_o    [1]          at least one request is set
// ---------------------------------------------------------------------------
module cvita_rr_arb_sel #(
  parameter int NUM_PORTS = 4,
  parameter int GW        = 2
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [GW-1:0]        last_grant_i,
  output logic [GW-1:0]        grant_o,
  output logic                 any_req_o
);

  int          idx;
  logic [GW-1:0] idx_g;

  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    idx       = 0;
    idx_g     = '0;
    // Offsets 1..NUM_PORTS: offset NUM_PORTS lands on last_grant itself,
    // so it still wins when it is the only requester.
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx   = (int'(last_grant_i) + i) % NUM_PORTS;
      idx_g = GW'(idx);
      if (!any_req_o && req_i[idx_g]) begin
        any_req_o = 1'b1;
        grant_o   = idx_g;
      end
    end
  end

endmodule

// File: rtl/cvita_pkt_rr_mux.sv
// ---------------------------------------------------------------------------
// cvita_pkt_rr_mux
// Packet-atomic round-robin mux: NUM_PORTS 64-bit CVITA AXI-Stream inputs
// share one output. A granted port owns the output from its header word to
// its tlast word. Optionally the header seqno is replaced by an output-side
// counter so downstream sees one gap-free sequence.
// Ports:
//   clk, reset, clear      clock, sync active-high reset, sync soft clear
//   i_tdata  [64*N]        input data, port k at [64k+63:64k]
//   i_tlast  [N]           input end of packet
//   i_tvalid [N]           input valid
//   i_tready [N]           input ready (only the granted port can be ready)
//   o_tdata  [64]          output data
//   o_tlast, o_tvalid      output end of packet / valid
//   o_tready               output ready
//   o_grant  [GW]          current or last granted port
//   o_dbg_state            FSM state, for observation only
//
// Handshake: a beat transfers on a rising edge where tvalid && tready are
// both high; tvalid never depends on tready, and o_tready passes straight
// through to i_tready of the granted port only, so the output transfer and
// the input transfer always happen on the same edge.
// ---------------------------------------------------------------------------
module cvita_pkt_rr_mux
  import cvita_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter bit REWRITE_SEQNUM = 1'b0,
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [64*NUM_PORTS-1:0]    i_tdata,
  input  logic [NUM_PORTS-1:0]       i_tlast,
  input  logic [NUM_PORTS-1:0]       i_tvalid,
  output logic [NUM_PORTS-1:0]       i_tready,
  output logic [63:0]                o_tdata,
  output logic                       o_tlast,
  output logic                       o_tvalid,
  input  logic                       o_tready,
  output logic [GW-1:0]              o_grant,
  output fsm_state_t                 o_dbg_state
);

  fsm_state_t         state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [SEQNO_W-1:0] seq_cnt_q, seq_cnt_d;

  logic [GW-1:0]      sel_grant;
  logic               sel_any;

  logic [63:0]        in_data [NUM_PORTS];
  logic [63:0]        g_data;
  logic               g_valid;
  logic               g_last;
  logic               active;
  logic               out_hs;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_unpack
    assign in_data[k] = i_tdata[64*k +: 64];
  end

  cvita_rr_arb_sel #(
    .NUM_PORTS (NUM_PORTS),
    .GW        (GW)
  ) u_arb_sel (
    .req_i        (i_tvalid),
    .last_grant_i (last_grant_q),
    .grant_o      (sel_grant),
    .any_req_o    (sel_any)
  );

  assign active  = (state_q != ST_IDLE);
  assign g_data  = in_data[grant_q];
  assign g_valid = i_tvalid[grant_q];
  assign g_last  = i_tlast[grant_q];
  assign out_hs  = active && g_valid && o_tready;

  // Next-state logic. The idle cycle used for arbitration is the single
  // bubble between packets; the grant stays fixed until the tlast beat.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    seq_cnt_d    = seq_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          grant_d = sel_grant;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (out_hs) begin
          seq_cnt_d = seq_cnt_q + SEQNO_W'(1);
          if (g_last) begin
            // Single-word packet: the port still drops to lowest priority.
            state_d      = ST_IDLE;
            last_grant_d = grant_q;
          end else begin
            state_d = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (out_hs && g_last) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output mux. Combinational pass-through of the granted port; only the
  // header seqno field is ever altered.
  always_comb begin
    o_tvalid = active && g_valid;
    o_tlast  = active && g_last;
    o_tdata  = g_data;
    if (REWRITE_SEQNUM && (state_q == ST_HDR)) begin
      o_tdata = hdr_set_seqno(g_data, seq_cnt_q);
    end
    i_tready = '0;
    if (active) begin
      i_tready[grant_q] = o_tready;
    end
  end

  // Clear shares the reset path, so it also overrides a same-cycle handshake.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_PORTS - 1);
      seq_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      seq_cnt_q    <= seq_cnt_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_dbg_state = state_q;

endmodule
